// File: rtl/fir_output_stage.sv
// fir_output_stage
//
// This is the output stage after the FIR filter. It takes the filter's
// full-precision result on each sample strobe and keeps one sample in every
// DECIM. Each kept sample is rounded half-to-even down to OW bits and then
// saturated to the signed OW-bit range. The result is queued in a small FIFO
// that a consumer drains over a valid/ready handshake.
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_reset_n   asynchronous active-low reset
//   i_ce        sample strobe; i_result is valid while i_ce is high
//   i_result    signed full-precision filter output (IW bits)
//   o_valid     FIFO head is valid
//   i_ready     consumer accepts the head this cycle
//   o_data      signed FIFO head (OW bits)
//   o_fill      FIFO occupancy, 0..2^LGFIFO
//   o_overflow  sticky: a sample was saturated
//   o_drop      sticky: a sample was lost because the FIFO was full
//   i_clear     synchronous clear of o_overflow and o_drop
//
// Handshake: a word transfers on every rising edge where o_valid && i_ready.
// While o_valid is high and i_ready is low, o_data holds its value. o_valid
// never falls without a transfer. o_data is meaningless while o_valid is low.
// The producer side has no backpressure. A sample that reaches a full FIFO
// with no read in the same cycle is discarded and flagged in o_drop.
module fir_output_stage #(
    parameter int IW     = 31,
    parameter int OW     = 16,
    parameter int SHIFT  = IW - OW,   // 1 <= SHIFT <= IW-OW
    parameter int DECIM  = 4,         // >= 1
    parameter int LGFIFO = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic [IW-1:0]     i_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OW-1:0]     o_data,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_overflow,
    output logic              o_drop,
    input  logic              i_clear
);

    // Width of the rounded value. This is one guard bit wider than OW when
    // SHIFT == IW-OW.
    localparam int RW    = IW + 1 - SHIFT;
    localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int DEPTH = 1 << LGFIFO;

    localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
    localparam logic [IW:0]   BIAS     = (IW+1)'((64'd1 << (SHIFT - 1)) - 64'd1);
    localparam logic [LGFIFO:0] FULL_CNT = (LGFIFO+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Decimation counter. It advances only on strobes.
    // ------------------------------------------------------------------
    logic [CW-1:0] dec_cnt;
    logic          accept;

    assign accept = i_ce && (dec_cnt == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dec_cnt <= '0;
        end else if (i_ce) begin
            if (dec_cnt == DEC_LAST)
                dec_cnt <= '0;
            else
                dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: convergent rounding.
    // The bias is half an output LSB minus one. The kept LSB of the input
    // (bit SHIFT) is added on top, so an exact tie rounds up only when the
    // truncated result would be odd. The sum is one bit wider than the input
    // and cannot wrap. Taking bits [IW:SHIFT] of the sign-extended sum is
    // the arithmetic right shift.
    // ------------------------------------------------------------------
    logic [IW:0]   rnd_sum;
    logic [RW-1:0] rnd_next;
    logic          s1_valid;
    logic [RW-1:0] s1_r;

    always_comb begin
        rnd_sum  = {i_result[IW-1], i_result} + BIAS
                 + {{IW{1'b0}}, i_result[SHIFT]};
        rnd_next = rnd_sum[IW:SHIFT];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept)
                s1_r <= rnd_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed saturation to OW bits.
    // The value fits when all bits above OW-1 equal the sign bit.
    // ------------------------------------------------------------------
    logic          sat_pos;
    logic          sat_neg;
    logic [OW-1:0] sat_data;
    logic          ovf_set;
    logic          s2_valid;
    logic [OW-1:0] s2_data;

    always_comb begin
        sat_pos  = !s1_r[RW-1] && (s1_r[RW-2:OW-1] != '0);
        sat_neg  =  s1_r[RW-1] && (s1_r[RW-2:OW-1] != '1);
        sat_data = s1_r[OW-1:0];
        if (sat_pos)
            sat_data = {1'b0, {(OW-1){1'b1}}};
        else if (sat_neg)
            sat_data = {1'b1, {(OW-1){1'b0}}};
        ovf_set  = s1_valid && (sat_pos || sat_neg);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= sat_data;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: circular pointers plus an explicit count.
    // When the FIFO is full and a read happens in the same cycle, the write
    // lands in the slot being vacated (wr_ptr == rd_ptr). o_data reads the
    // old contents combinationally, so the head stays correct for that edge.
    // ------------------------------------------------------------------
    logic [OW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr;
    logic [LGFIFO-1:0] rd_ptr;
    logic [LGFIFO:0]   count;
    logic              full;
    logic              fifo_rd;
    logic              fifo_wr;
    logic              drop_set;

    always_comb begin
        full     = (count == FULL_CNT);
        fifo_rd  = (count != '0) && i_ready;
        fifo_wr  = s2_valid && (!full || fifo_rd);
        drop_set = s2_valid && full && !fifo_rd;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= s2_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_fill  = count;

    // ------------------------------------------------------------------
    // Sticky flags. A set event wins over a clear in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            if (ovf_set)
                o_overflow <= 1'b1;
            else if (i_clear)
                o_overflow <= 1'b0;

            if (drop_set)
                o_drop <= 1'b1;
            else if (i_clear)
                o_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage.
//
// Two instances share one clock and reset. dut1 uses DECIM=1 and dut4 uses
// DECIM=4. Each stimulus task pushes the expected output into that
// instance's queue as the sample is issued. A separate monitor per instance
// pops from its queue and compares whenever a word is handed over.
module tb_fir_output_stage;

    localparam int IW     = 31;
    localparam int OW     = 16;
    localparam int SHIFT  = IW - OW;
    localparam int LGFIFO = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            ce1, rdy1, clr1, v1, ovf1, drop1;
    logic [IW-1:0]   res1;
    logic [OW-1:0]   d1;
    logic [LGFIFO:0] fill1;

    logic            ce4, rdy4, clr4, v4, ovf4, drop4;
    logic [IW-1:0]   res4;
    logic [OW-1:0]   d4;
    logic [LGFIFO:0] fill4;

    fir_output_stage #(.IW(IW), .OW(OW), .SHIFT(SHIFT), .DECIM(1), .LGFIFO(LGFIFO)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce1), .i_result(res1),
        .o_valid(v1), .i_ready(rdy1), .o_data(d1), .o_fill(fill1),
        .o_overflow(ovf1), .o_drop(drop1), .i_clear(clr1)
    );

    fir_output_stage #(.IW(IW), .OW(OW), .SHIFT(SHIFT), .DECIM(4), .LGFIFO(LGFIFO)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce4), .i_result(res4),
        .o_valid(v4), .i_ready(rdy4), .o_data(d4), .o_fill(fill4),
        .o_overflow(ovf4), .o_drop(drop4), .i_clear(clr4)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q1[$];
    logic [OW-1:0] exp_q4[$];
    int checks = 0;
    int errors = 0;
    int out_cnt4 = 0;
    int dcnt4 = 0;
    bit sat_seen1 = 0;
    bit sat_seen4 = 0;
    logic [OW-1:0] e1, e4;

    // Reference: the exact quotient x / 2^SHIFT rounded to nearest with ties
    // to even, then clamped to the signed OW-bit range.
    function automatic logic [OW-1:0] ref_out(input longint x, output bit sat);
        longint q, rem, half, lim;
        q    = x >>> SHIFT;              // floor division
        rem  = x - (q <<< SHIFT);        // 0 .. 2^SHIFT-1
        half = 64'sd1 <<< (SHIFT - 1);
        if (rem > half || (rem == half && (q % 2 != 0)))
            q = q + 1;
        lim = 64'sd1 <<< (OW - 1);
        sat = 1'b0;
        if (q > lim - 1) begin
            q = lim - 1;
            sat = 1'b1;
        end else if (q < -lim) begin
            q = -lim;
            sat = 1'b1;
        end
        return q[OW-1:0];
    endfunction

    function automatic longint rnd_val();
        logic signed [15:0] k;
        logic signed [30:0] t;
        longint v;
        case ($urandom_range(0, 3))
            0: begin
                k = 16'($urandom);
                v = (longint'(k) <<< SHIFT) + 16384;   // exact tie
            end
            1: begin
                v = ($urandom_range(0, 1) != 0) ? (64'sd1 <<< 30) - longint'($urandom_range(0, 40000))
                                                : -(64'sd1 <<< 30) + longint'($urandom_range(0, 40000));
            end
            default: begin
                t = 31'($urandom);
                v = t;
            end
        endcase
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send1(input longint v, input bit keep);
        bit s;
        logic [OW-1:0] e;
        e = ref_out(v, s);
        ce1  = 1'b1;
        res1 = v[IW-1:0];
        if (keep) begin
            exp_q1.push_back(e);
            if (s) sat_seen1 = 1'b1;
        end
        tick();
        ce1 = 1'b0;
    endtask

    task automatic send4(input longint v);
        bit s;
        logic [OW-1:0] e;
        e = ref_out(v, s);
        ce4  = 1'b1;
        res4 = v[IW-1:0];
        if (dcnt4 == 0) begin
            exp_q4.push_back(e);
            if (s) sat_seen4 = 1'b1;
        end
        dcnt4 = (dcnt4 + 1) % 4;
        tick();
        ce4 = 1'b0;
    endtask

    task automatic clear1();
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
    endtask

    task automatic drain1();
        int n;
        n = 0;
        rdy1 = 1'b1;
        while ((exp_q1.size() != 0 || v1) && n < 200) begin
            tick();
            n++;
        end
        chk("drain1_left", longint'(exp_q1.size()), 0);
    endtask

    task automatic drain4();
        int n;
        n = 0;
        rdy4 = 1'b1;
        while ((exp_q4.size() != 0 || v4) && n < 200) begin
            tick();
            n++;
        end
        chk("drain4_left", longint'(exp_q4.size()), 0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && v1 && rdy1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL out1_unexpected got %h want none", d1);
            end else begin
                e1 = exp_q1.pop_front();
                if (d1 !== e1) begin
                    errors++;
                    $display("FAIL out1_data got %h want %h", d1, e1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v4 && rdy4) begin
            checks++;
            out_cnt4++;
            if (exp_q4.size() == 0) begin
                errors++;
                $display("FAIL out4_unexpected got %h want none", d4);
            end else begin
                e4 = exp_q4.pop_front();
                if (d4 !== e4) begin
                    errors++;
                    $display("FAIL out4_data got %h want %h", d4, e4);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [OW-1:0] held;
        bit s;
        logic [OW-1:0] e;

        rst_n = 1'b0;
        ce1 = 0; rdy1 = 0; clr1 = 0; res1 = '0;
        ce4 = 0; rdy4 = 0; clr4 = 0; res4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(v1), 0);
        chk("rst_fill", longint'(fill1), 0);
        chk("rst_ovf", longint'(ovf1), 0);
        chk("rst_drop", longint'(drop1), 0);
        chk("rst_data", longint'(d1), 0);
        chk("rst_valid4", longint'(v4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rounding, ties to even on both signs.
        rdy1 = 1'b1;
        send1(49152, 1);
        send1(81920, 1);
        send1(81921, 1);
        send1(-49152, 1);
        send1(-81920, 1);
        drain1();
        chk("round_ovf", longint'(ovf1), 0);

        // Saturation and the sticky overflow flag.
        send1((64'sd1 <<< 30) - 1, 1);
        send1(-(64'sd1 <<< 30), 1);
        drain1();
        chk("sat_ovf_set", longint'(ovf1), 1);
        clear1();
        chk("sat_ovf_cleared", longint'(ovf1), 0);
        send1((64'sd1 <<< 30) - 1, 1);  // enters stage 1 at this edge
        clr1 = 1'b1;                    // clear on the edge where stage 2 saturates
        tick();
        clr1 = 1'b0;
        chk("sat_vs_clear", longint'(ovf1), 1);
        drain1();
        clear1();
        chk("sat_ovf_cleared2", longint'(ovf1), 0);

        // Decimation by 4, with idle gaps between strobes.
        rdy4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send4(longint'(k) <<< SHIFT);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain4();
        chk("decim_count", longint'(out_cnt4), 3);
        chk("decim_fill", longint'(fill4), 0);

        // Backpressure: 10 samples into an 8-deep FIFO with no reads.
        rdy1 = 1'b0;
        for (int k = 0; k < 10; k++)
            send1(longint'(k) <<< SHIFT, k < 8);
        repeat (4) tick();
        chk("bp_fill", longint'(fill1), 8);
        chk("bp_drop", longint'(drop1), 1);
        held = d1;
        chk("bp_head", longint'(held), 0);
        repeat (3) begin
            tick();
            chk("bp_stable", longint'(d1), longint'(held));
        end
        drain1();
        clear1();
        chk("bp_drop_cleared", longint'(drop1), 0);

        // Full FIFO with a read and a write on every edge.
        rdy1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rdy1 = (c >= 10);
            send1(longint'(c + 100) <<< SHIFT, 1);
            if (c >= 9)
                chk("full_rw_fill", longint'(fill1), 8);
        end
        chk("full_rw_drop", longint'(drop1), 0);
        drain1();
        chk("full_rw_drop_end", longint'(drop1), 0);

        // Reset with 5 entries queued and 2 samples in the pipeline.
        rdy1 = 1'b0;
        for (int k = 0; k < 5; k++)
            send1(longint'(k + 20) <<< SHIFT, 1);
        repeat (3) tick();
        chk("rst_mid_fill_before", longint'(fill1), 5);
        send1(longint'(30) <<< SHIFT, 1);
        send1(longint'(31) <<< SHIFT, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", longint'(v1), 0);
        chk("rst_mid_fill", longint'(fill1), 0);
        exp_q1.delete();
        exp_q4.delete();
        dcnt4 = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        e = ref_out(-(longint'(7) <<< SHIFT) - 3, s);
        send1(-(longint'(7) <<< SHIFT) - 3, 1);   // edge E0
        tick();                                  // edge E1
        chk("rst_lat_e1_valid", longint'(v1), 0);
        tick();                                  // edge E2
        chk("rst_lat_e2_valid", longint'(v1), 1);
        chk("rst_lat_e2_fill", longint'(fill1), 1);
        chk("rst_lat_data", longint'(d1), longint'(e));
        drain1();

        // Random traffic on dut1. Issue is gated so the FIFO cannot overflow.
        clear1();
        sat_seen1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rdy1 = ($urandom_range(0, 2) != 0);
            if (exp_q1.size() < 6 && $urandom_range(0, 3) != 0)
                send1(rnd_val(), 1);
            else
                tick();
        end
        drain1();
        chk("rand1_ovf", longint'(ovf1), longint'(sat_seen1));
        chk("rand1_drop", longint'(drop1), 0);

        // Random traffic on dut4.
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        sat_seen4 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rdy4 = ($urandom_range(0, 2) != 0);
            if (exp_q4.size() < 6 && $urandom_range(0, 1) != 0)
                send4(rnd_val());
            else
                tick();
        end
        drain4();
        chk("rand4_ovf", longint'(ovf4), longint'(sat_seen4));
        chk("rand4_drop", longint'(drop4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
